// File: rtl/pokey_bus_master.sv
// Host-side bus initiator for POKEY: queues register requests and replays them
// as 6502-style phi2 bus cycles, returning read data through a one-clk strobe.
module pokey_bus_master #(
   parameter int PHI2_HALF  = 28,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [3:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       phi2,
   output logic       readHighWriteLow,
   output logic       cs0Bar,
   output logic [3:0] bus_a,
   output logic [7:0] bus_dout,
   input  logic [7:0] bus_din
);

   localparam int CW = $clog2(PHI2_HALF);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic       write;
      logic [3:0] addr;
      logic [7:0] wdata;
   } req_t;

   typedef enum logic {IDLE, CYCLE} state_t;

   logic [CW-1:0] cnt;
   logic          tc;
   logic          fall_evt;

   assign tc       = (cnt == CW'(PHI2_HALF - 1));
   assign fall_evt = tc && phi2;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt  <= '0;
         phi2 <= 1'b0;
      end else if (tc) begin
         cnt  <= '0;
         phi2 <= ~phi2;
      end else begin
         cnt  <= cnt + CW'(1);
      end
   end

   req_t          mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          push, pop;
   req_t          head;

   // Depth is a power of two, so the MSB of the occupancy count is the full flag.
   assign req_ready = !count[AW] && !clr;
   assign push      = req_valid && req_ready;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {req_write, req_addr, req_wdata};
   end

   state_t     state, state_n;
   logic       cs_n, rw_n, rsp_valid_n;
   logic [3:0] a_n;
   logic [7:0] dout_n, rsp_data_n;

   always_comb begin
      state_n     = state;
      pop         = 1'b0;
      cs_n        = cs0Bar;
      rw_n        = readHighWriteLow;
      a_n         = bus_a;
      dout_n      = bus_dout;
      rsp_valid_n = 1'b0;
      rsp_data_n  = rsp_data;
      if (fall_evt) begin
         // Read data is taken on the same edge that ends the cycle; bus_din is
         // only trusted here, after POKEY has driven it through the high phase.
         if (state == CYCLE && readHighWriteLow) begin
            rsp_valid_n = 1'b1;
            rsp_data_n  = bus_din;
         end
         if (count != '0) begin
            pop     = 1'b1;
            state_n = CYCLE;
            cs_n    = 1'b0;
            rw_n    = ~head.write;
            a_n     = head.addr;
            dout_n  = head.write ? head.wdata : 8'h00;
         end else begin
            state_n = IDLE;
            cs_n    = 1'b1;
            rw_n    = 1'b1;
            a_n     = 4'h0;
            dout_n  = 8'h00;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state            <= IDLE;
         cs0Bar           <= 1'b1;
         readHighWriteLow <= 1'b1;
         bus_a            <= 4'h0;
         bus_dout         <= 8'h00;
         rsp_valid        <= 1'b0;
         rsp_data         <= 8'h00;
      end else begin
         state            <= state_n;
         cs0Bar           <= cs_n;
         readHighWriteLow <= rw_n;
         bus_a            <= a_n;
         bus_dout         <= dout_n;
         rsp_valid        <= rsp_valid_n;
         rsp_data         <= rsp_data_n;
      end
   end

   assign busy = (count != '0) || (state == CYCLE);

endmodule

// File: tb/tb_pokey_bus_master.sv
// Bench for pokey_bus_master: a transaction-queue model with phi2 timing derived
// from the clk count since reset release, plus a small POKEY read-data model.
module tb_pokey_bus_master;

   localparam int HALF  = 28;
   localparam int PER   = 2 * HALF;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       clr;
   logic       req_valid, req_ready, req_write;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy, phi2, readHighWriteLow, cs0Bar;
   logic [3:0] bus_a;
   logic [7:0] bus_dout, bus_din;

   always #5 clk = ~clk;

   pokey_bus_master #(.PHI2_HALF(HALF), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .phi2(phi2), .readHighWriteLow(readHighWriteLow), .cs0Bar(cs0Bar),
      .bus_a(bus_a), .bus_dout(bus_dout), .bus_din(bus_din)
   );

   // POKEY drives Dout only while read-selected and phi2 is high.
   logic [7:0] rd_table [16];
   assign bus_din = (!cs0Bar && readHighWriteLow && phi2) ? rd_table[bus_a] : 8'hxx;

   typedef struct {
      logic       write;
      logic [3:0] addr;
      logic [7:0] wdata;
   } req_t;

   req_t       q[$];
   req_t       cur;
   bit         cur_v;
   int         n;
   bit         m_rsp;
   logic [7:0] m_rdata;
   bit         last_acc;
   int         checks, failures, rsp_cnt, base;
   int         rsp_n[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      q.delete();
      cur_v = 0;
      m_rsp = 0;
      m_rdata = 8'h00;
   endtask

   task automatic check_all();
      bit e_phi2;
      e_phi2 = !clr && ((n / HALF) % 2 == 1);
      chk("phi2", 32'(phi2), 32'(e_phi2));
      chk("cs0Bar", 32'(cs0Bar), 32'(!cur_v));
      chk("rhwl", 32'(readHighWriteLow), cur_v ? 32'(!cur.write) : 32'd1);
      chk("bus_a", 32'(bus_a), cur_v ? 32'(cur.addr) : 32'd0);
      chk("bus_dout", 32'(bus_dout), (cur_v && cur.write) ? 32'(cur.wdata) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      chk("rsp_data", 32'(rsp_data), 32'(m_rdata));
      chk("busy", 32'(busy), 32'(q.size() != 0 || cur_v));
      if (!clr) chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
   endtask

   task automatic tick();
      bit   acc;
      req_t r;
      @(posedge clk);
      acc   = 0;
      m_rsp = 0;
      if (clr) model_reset();
      else begin
         n++;
         acc = req_valid && (q.size() < DEPTH);
         if (n % PER == 0) begin
            if (cur_v && !cur.write) begin
               m_rsp   = 1;
               m_rdata = rd_table[cur.addr];
            end
            cur_v = 0;
            if (q.size() > 0) begin
               cur   = q.pop_front();
               cur_v = 1;
            end
         end
         if (acc) begin
            r.write = req_write;
            r.addr  = req_addr;
            r.wdata = req_wdata;
            q.push_back(r);
         end
      end
      last_acc = acc;
      #1;
      if (rsp_valid === 1'b1) begin
         rsp_cnt++;
         rsp_n.push_back(n);
      end
      check_all();
   endtask

   task automatic idle(input int k);
      req_valid = 0;
      for (int i = 0; i < k; i++) begin
         req_write = 1'($urandom);
         req_addr  = 4'($urandom);
         req_wdata = 8'($urandom);
         tick();
      end
   endtask

   task automatic push_req(input bit w, input logic [3:0] a, input logic [7:0] d);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (last_acc) break;
      end
      chk("push_accept", 32'(last_acc), 32'd1);
      req_valid = 0;
   endtask

   task automatic drain();
      req_valid = 0;
      for (int i = 0; i < 2000 && (busy !== 1'b0 || q.size() != 0 || cur_v); i++) tick();
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   task automatic wait_cycle();
      for (int i = 0; i < 200 && cs0Bar !== 1'b0; i++) tick();
      chk("cycle_start", 32'(cs0Bar), 32'd0);
   endtask

   // Raise clr between clock edges and hold it for two edges.
   task automatic async_reset();
      #2;
      clr = 1;
      model_reset();
      #1;
      check_all();
      tick();
      tick();
      clr = 0;
   endtask

   initial begin
      checks = 0; failures = 0; rsp_cnt = 0;
      clr = 1; req_valid = 0; req_write = 0; req_addr = 4'h0; req_wdata = 8'h00;
      foreach (rd_table[i]) rd_table[i] = 8'($urandom);
      rd_table[10] = 8'h5A;
      model_reset();
      repeat (3) tick();
      clr = 0;

      // reset mid high phase, then watch free-running phi2
      idle(40);
      async_reset();
      idle(130);

      // single write
      base = rsp_cnt;
      push_req(1'b1, 4'h1, 8'hAF);
      drain();
      chk("write_no_rsp", 32'(rsp_cnt - base), 32'd0);

      // single read
      base = rsp_cnt;
      push_req(1'b0, 4'hA, 8'h00);
      drain();
      chk("read_rsp_cnt", 32'(rsp_cnt - base), 32'd1);
      chk("read_data", 32'(rsp_data), 32'h5A);

      // five writes queued behind a running cycle
      push_req(1'b0, 4'h3, 8'h00);
      wait_cycle();
      for (int i = 0; i < 5; i++) begin
         push_req(1'b1, 4'(i + 4), 8'($urandom));
         if (i == 3) chk("ready_full", 32'(req_ready), 32'd0);
      end
      drain();

      // reset 20 clks into the high phase of a read
      base = rsp_cnt;
      push_req(1'b0, 4'h7, 8'h00);
      wait_cycle();
      idle(HALF + 20);
      async_reset();
      idle(PER + 10);
      chk("abort_no_rsp", 32'(rsp_cnt - base), 32'd0);

      // SKCTL write followed by two reads
      base = rsp_cnt;
      rsp_n.delete();
      push_req(1'b1, 4'hF, 8'h03);
      push_req(1'b0, 4'hA, 8'h00);
      push_req(1'b0, 4'hA, 8'h00);
      drain();
      chk("skctl_rsp_cnt", 32'(rsp_cnt - base), 32'd2);
      chk("skctl_gap", (rsp_n.size() >= 2) ? 32'(rsp_n[1] - rsp_n[0]) : 32'hFFFF_FFFF, 32'(PER));

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         idle(($urandom_range(0, 7) == 0) ? $urandom_range(10, 80) : $urandom_range(0, 3));
         push_req(1'($urandom), 4'($urandom), 8'($urandom));
         if (it % 25 == 24) begin
            drain();
            foreach (rd_table[i]) rd_table[i] = 8'($urandom);
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
